// File: rtl/sine_taylor_arbiter_if.sv
// -----------------------------------------------------------------------------
// sine_taylor_arbiter_if
//
// Purpose:
//   Bundles every non-clock/reset signal of the sine_taylor_arbiter: the
//   requester-side valid/ready streams, the shared sine_taylor core port and
//   the status outputs.
//
// Modports:
//   master : the arbiter's view (drives req_ready, res_*, core_* controls,
//            busy, grant_id).
//   slave  : the surrounding system's view (requesters plus the core).
//
// Signal summary:
//   enable          1 = new grants allowed
//   req_data        requester i sample at [i*G_DWIDTH +: G_DWIDTH]
//   req_valid       per-requester valid
//   req_ready       per-requester ready, one-hot or zero
//   res_data        result, broadcast to all requesters
//   res_err         1 = result produced by timeout recovery
//   res_valid       one-hot valid towards the owning requester
//   res_ready       per-requester ready
//   core_enable     core enable
//   core_reset      core reset, active-high
//   core_din        core sample input, with core_din_valid / core_din_ready
//   core_dout       core result, with core_dout_valid / core_dout_ready
//   busy            high whenever the arbiter is not arbitrating
//   grant_id        index of the current/last granted requester
// -----------------------------------------------------------------------------
interface sine_taylor_arbiter_if #(
    parameter int G_DWIDTH  = 16,
    parameter int G_NUM_REQ = 4
);
    localparam int ID_W = (G_NUM_REQ > 1) ? $clog2(G_NUM_REQ) : 1;

    logic                          enable;
    logic [G_NUM_REQ*G_DWIDTH-1:0] req_data;
    logic [G_NUM_REQ-1:0]          req_valid;
    logic [G_NUM_REQ-1:0]          req_ready;
    logic [G_DWIDTH-1:0]           res_data;
    logic                          res_err;
    logic [G_NUM_REQ-1:0]          res_valid;
    logic [G_NUM_REQ-1:0]          res_ready;
    logic                          core_enable;
    logic                          core_reset;
    logic [G_DWIDTH-1:0]           core_din;
    logic                          core_din_valid;
    logic                          core_din_ready;
    logic [G_DWIDTH-1:0]           core_dout;
    logic                          core_dout_valid;
    logic                          core_dout_ready;
    logic                          busy;
    logic [ID_W-1:0]               grant_id;

    modport master (
        input  enable,
        input  req_data,
        input  req_valid,
        output req_ready,
        output res_data,
        output res_err,
        output res_valid,
        input  res_ready,
        output core_enable,
        output core_reset,
        output core_din,
        output core_din_valid,
        input  core_din_ready,
        input  core_dout,
        input  core_dout_valid,
        output core_dout_ready,
        output busy,
        output grant_id
    );

    modport slave (
        output enable,
        output req_data,
        output req_valid,
        input  req_ready,
        input  res_data,
        input  res_err,
        input  res_valid,
        output res_ready,
        input  core_enable,
        input  core_reset,
        input  core_din,
        input  core_din_valid,
        output core_din_ready,
        output core_dout,
        output core_dout_valid,
        input  core_dout_ready,
        input  busy,
        input  grant_id
    );
endinterface

// File: rtl/sine_taylor_arbiter.sv
// -----------------------------------------------------------------------------
// sine_taylor_arbiter
//
// Purpose:
//   Round-robin scheduler sharing one sine_taylor core between G_NUM_REQ
//   valid/ready requester streams. One job at a time runs through
//   ARB -> ISSUE -> WAIT -> DELIVER -> ARB. The result goes back only to the
//   requester that was granted. A watchdog recovers a hung core by pulsing
//   core_reset and returning an error-flagged zero result.
//
// Parameters:
//   G_DWIDTH   sample width (must match the core)
//   G_NUM_REQ  number of requesters (2..16)
//   G_TIMEOUT  max cycles spent in ISSUE or WAIT before recovery
//
// Ports:
//   clk      system clock
//   reset_n  synchronous, active-low reset
//   bus      sine_taylor_arbiter_if.master (requesters, core, status)
// -----------------------------------------------------------------------------
module sine_taylor_arbiter #(
    parameter int G_DWIDTH  = 16,
    parameter int G_NUM_REQ = 4,
    parameter int G_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sine_taylor_arbiter_if.master bus
);
    localparam int ID_W = (G_NUM_REQ > 1) ? $clog2(G_NUM_REQ) : 1;
    localparam int WD_W = (G_TIMEOUT > 1) ? $clog2(G_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Registered state and outputs
    // -------------------------------------------------------------------------
    state_t                state_q;
    logic [ID_W-1:0]       ptr_q;
    logic [ID_W-1:0]       grant_q;
    logic [G_DWIDTH-1:0]   core_din_q;
    logic                  core_din_valid_q;
    logic                  core_dout_ready_q;
    logic [G_DWIDTH-1:0]   res_data_q;
    logic                  res_err_q;
    logic [G_NUM_REQ-1:0]  res_valid_q;
    logic [WD_W-1:0]       wdog_q;
    logic                  core_reset_q;
    logic                  core_enable_q;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                  win_found;
    logic [ID_W-1:0]       win_idx;
    logic [G_DWIDTH-1:0]   win_data;
    logic                  accept;
    logic                  wd_expired;
    logic [ID_W-1:0]       ptr_d;

    // One-hot vector with only bit 'idx' set.
    function automatic logic [G_NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [G_NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: first set bit of 'valid' searching ptr, ptr+1, ...
    // modulo G_NUM_REQ. Scanning from the farthest offset towards the nearest
    // lets the nearest hit overwrite the others. MSB of the result = found.
    function automatic logic [ID_W:0] rr_pick(
        input logic [G_NUM_REQ-1:0] valid,
        input logic [ID_W-1:0]      ptr
    );
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx;
        res = '0;
        for (int k = G_NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % G_NUM_REQ);
            if (valid[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        logic [ID_W:0] pick;
        pick      = rr_pick(bus.req_valid, ptr_q);
        win_found = pick[ID_W];
        win_idx   = pick[ID_W-1:0];
    end

    // Sample of the winning requester.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < G_NUM_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_data = bus.req_data[i*G_DWIDTH +: G_DWIDTH];
            end
        end
    end

    // reset_n gates the handshake so req_ready reads zero while held in reset.
    assign accept     = reset_n && (state_q == ST_ARB) && bus.enable && win_found;
    assign wd_expired = (wdog_q == WD_W'(G_TIMEOUT - 1));
    // Pointer moves one past the requester just served, wrapping to 0.
    assign ptr_d      = (grant_q == ID_W'(G_NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Aborts any in-flight job and resets the core along with it.
            state_q           <= ST_ARB;
            ptr_q             <= '0;
            grant_q           <= '0;
            core_din_q        <= '0;
            core_din_valid_q  <= 1'b0;
            core_dout_ready_q <= 1'b0;
            res_data_q        <= '0;
            res_err_q         <= 1'b0;
            res_valid_q       <= '0;
            wdog_q            <= '0;
            core_reset_q      <= 1'b1;
            core_enable_q     <= 1'b0;
        end else begin
            // core_reset is a single-cycle pulse unless recovery re-asserts it.
            core_reset_q  <= 1'b0;
            core_enable_q <= 1'b1;

            case (state_q)
                ST_ARB: begin
                    if (accept) begin
                        core_din_q       <= win_data;
                        grant_q          <= win_idx;
                        core_din_valid_q <= 1'b1;
                        wdog_q           <= '0;
                        state_q          <= ST_ISSUE;
                    end
                end

                ST_ISSUE, ST_WAIT: begin
                    if ((state_q == ST_ISSUE) && core_din_valid_q && bus.core_din_ready) begin
                        core_din_valid_q  <= 1'b0;
                        core_dout_ready_q <= 1'b1;
                        wdog_q            <= '0;
                        state_q           <= ST_WAIT;
                    end else if ((state_q == ST_WAIT) && core_dout_ready_q && bus.core_dout_valid) begin
                        res_data_q        <= bus.core_dout;
                        res_err_q         <= 1'b0;
                        core_dout_ready_q <= 1'b0;
                        res_valid_q       <= onehot(grant_q);
                        state_q           <= ST_DELIVER;
                    end else if (wd_expired) begin
                        // Hung core: reset it and hand back an error-flagged zero.
                        core_reset_q      <= 1'b1;
                        core_din_valid_q  <= 1'b0;
                        core_dout_ready_q <= 1'b0;
                        res_data_q        <= '0;
                        res_err_q         <= 1'b1;
                        res_valid_q       <= onehot(grant_q);
                        state_q           <= ST_DELIVER;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end

                ST_DELIVER: begin
                    // Only the owner's res_ready can complete delivery.
                    if (res_valid_q[grant_q] && bus.res_ready[grant_q]) begin
                        res_valid_q <= '0;
                        ptr_q       <= ptr_d;
                        state_q     <= ST_ARB;
                    end
                end

                default: begin
                    state_q <= ST_ARB;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.req_ready       = accept ? onehot(win_idx) : '0;
    assign bus.res_data        = res_data_q;
    assign bus.res_err         = res_err_q;
    assign bus.res_valid       = res_valid_q;
    assign bus.core_enable     = core_enable_q;
    assign bus.core_reset      = core_reset_q;
    assign bus.core_din        = core_din_q;
    assign bus.core_din_valid  = core_din_valid_q;
    assign bus.core_dout_ready = core_dout_ready_q;
    assign bus.busy            = (state_q != ST_ARB);
    assign bus.grant_id        = grant_q;

endmodule
